// File: rtl/pic_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pic_move_ctrl
// Function : Bouncing 48x48 picture window scheduler. It sequences the ROM
//            address and emits a valid flag aligned with ROM read data.
// Option   : PIC_PAUSE_EN adds the pause port, which freezes motion.
// Revision : 1.0 - initial release
// ============================================================================
module pic_move_ctrl #(
    parameter int H_ACT     = 640,
    parameter int V_ACT     = 480,
    parameter int WIDTH     = 48,
    parameter int HEIGHT    = 48,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [11:0] addr_h,
    input  logic [11:0] addr_v,
`ifdef PIC_PAUSE_EN
    input  logic        pause,
`endif
    output logic [13:0] rom_address,
    output logic        pic_valid,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y
);

    localparam logic [13:0] c_ADDR_LAST = 14'(WIDTH * HEIGHT - 1);
    localparam logic [12:0] c_X_MAX     = 13'(H_ACT - WIDTH);
    localparam logic [12:0] c_Y_MAX     = 13'(V_ACT - HEIGHT);
    localparam logic [11:0] c_X_MAX12   = 12'(H_ACT - WIDTH);
    localparam logic [11:0] c_Y_MAX12   = 12'(V_ACT - HEIGHT);
    localparam logic [11:0] c_X_INIT    = 12'((H_ACT - WIDTH) / 2);
    localparam logic [11:0] c_Y_INIT    = 12'((V_ACT - HEIGHT) / 2);
    localparam logic [12:0] c_STEP13    = 13'(STEP);
    localparam logic [11:0] c_STEP12    = 12'(STEP);
    localparam logic [12:0] c_W_M1      = 13'(WIDTH - 1);
    localparam logic [12:0] c_H_M1      = 13'(HEIGHT - 1);
    localparam logic [11:0] c_H_LAST    = 12'(H_ACT - 1);
    localparam logic [11:0] c_V_LAST    = 12'(V_ACT - 1);
    localparam int          c_FCNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(FRAME_DIV - 1);

    localparam logic [0:0] S_RIGHT = 1'b0;
    localparam logic [0:0] S_LEFT  = 1'b1;
    localparam logic [0:0] S_DOWN  = 1'b0;
    localparam logic [0:0] S_UP    = 1'b1;

    logic [13:0]         r_addr_cnt;
    logic                r_hit_d1;
    logic [c_FCNT_W-1:0] r_frame_cnt;
    logic [0:0]          r_x_state;
    logic [0:0]          r_y_state;
    logic [11:0]         r_pos_x;
    logic [11:0]         r_pos_y;

    logic [0:0]          w_x_state_nxt;
    logic [0:0]          w_y_state_nxt;
    logic [11:0]         w_pos_x_nxt;
    logic [11:0]         w_pos_y_nxt;
    logic [12:0]         w_h13;
    logic [12:0]         w_v13;
    logic [12:0]         w_px13;
    logic [12:0]         w_py13;
    logic                w_hit;
    logic                w_frame_end;
    logic                w_hold;
    logic                w_move_due;

    // Window compares are done one bit wider so pos+WIDTH-1 cannot wrap.
    assign w_h13  = {1'b0, addr_h};
    assign w_v13  = {1'b0, addr_v};
    assign w_px13 = {1'b0, r_pos_x};
    assign w_py13 = {1'b0, r_pos_y};

    assign w_hit = pix_valid
                && (w_h13 >= w_px13) && (w_h13 <= w_px13 + c_W_M1)
                && (w_v13 >= w_py13) && (w_v13 <= w_py13 + c_H_M1);

    assign w_frame_end = pix_valid && (addr_h == c_H_LAST) && (addr_v == c_V_LAST);

`ifdef PIC_PAUSE_EN
    assign w_hold = pause;
`else
    assign w_hold = 1'b0;
`endif

    assign w_move_due = w_frame_end && !w_hold && (r_frame_cnt == c_FCNT_LAST);

    // rom_address presents the address of the pixel hit on the previous cycle.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_cnt  <= '0;
            rom_address <= '0;
            r_hit_d1    <= 1'b0;
            pic_valid   <= 1'b0;
        end else begin
            if (w_frame_end) begin
                r_addr_cnt <= '0;
            end else if (w_hit) begin
                r_addr_cnt <= (r_addr_cnt == c_ADDR_LAST) ? 14'd0 : r_addr_cnt + 14'd1;
            end
            if (w_hit) begin
                rom_address <= r_addr_cnt;
            end
            r_hit_d1  <= w_hit;
            pic_valid <= r_hit_d1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end && !w_hold) begin
            r_frame_cnt <= (r_frame_cnt == c_FCNT_LAST) ? '0 : r_frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_state <= S_RIGHT;
            r_y_state <= S_DOWN;
            r_pos_x   <= c_X_INIT;
            r_pos_y   <= c_Y_INIT;
        end else begin
            r_x_state <= w_x_state_nxt;
            r_y_state <= w_y_state_nxt;
            r_pos_x   <= w_pos_x_nxt;
            r_pos_y   <= w_pos_y_nxt;
        end
    end

    // Edges clamp exactly and reverse direction in the same move.
    always_comb begin
        w_x_state_nxt = r_x_state;
        w_y_state_nxt = r_y_state;
        w_pos_x_nxt   = r_pos_x;
        w_pos_y_nxt   = r_pos_y;
        if (w_move_due) begin
            case (r_x_state)
                S_RIGHT: begin
                    if (w_px13 + c_STEP13 >= c_X_MAX) begin
                        w_pos_x_nxt   = c_X_MAX12;
                        w_x_state_nxt = S_LEFT;
                    end else begin
                        w_pos_x_nxt = r_pos_x + c_STEP12;
                    end
                end
                default: begin
                    if (w_px13 <= c_STEP13) begin
                        w_pos_x_nxt   = 12'd0;
                        w_x_state_nxt = S_RIGHT;
                    end else begin
                        w_pos_x_nxt = r_pos_x - c_STEP12;
                    end
                end
            endcase
            case (r_y_state)
                S_DOWN: begin
                    if (w_py13 + c_STEP13 >= c_Y_MAX) begin
                        w_pos_y_nxt   = c_Y_MAX12;
                        w_y_state_nxt = S_UP;
                    end else begin
                        w_pos_y_nxt = r_pos_y + c_STEP12;
                    end
                end
                default: begin
                    if (w_py13 <= c_STEP13) begin
                        w_pos_y_nxt   = 12'd0;
                        w_y_state_nxt = S_DOWN;
                    end else begin
                        w_pos_y_nxt = r_pos_y - c_STEP12;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pos_x = r_pos_x;
        pos_y = r_pos_y;
    end

endmodule
`default_nettype wire

// File: tb/tb_pic_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_move_ctrl
// Function : Scoreboard bench for pic_move_ctrl (STEP=7, FRAME_DIV=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_move_ctrl;

    localparam int c_STEP = 7;
    localparam int c_XMAX = 592;
    localparam int c_YMAX = 432;

    typedef struct packed {
        logic        hit;
        logic [13:0] addr;
    } exp_t;

    logic        vga_clk   = 1'b0;
    logic        rst_n     = 1'b0;
    logic        pix_valid = 1'b0;
    logic [11:0] addr_h    = '0;
    logic [11:0] addr_v    = '0;
    logic        pause_drv = 1'b0;
    logic [13:0] rom_address;
    logic        pic_valid;
    logic [11:0] pos_x;
    logic [11:0] pos_y;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   pv_seen = 0;
    int   mdl_x, mdl_y, mdl_fcnt, mdl_cnt;
    logic mdl_right, mdl_down;

    always #5 vga_clk = ~vga_clk;

    pic_move_ctrl #(
        .H_ACT    (640),
        .V_ACT    (480),
        .WIDTH    (48),
        .HEIGHT   (48),
        .STEP     (c_STEP),
        .FRAME_DIV(2)
    ) u_dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .addr_h     (addr_h),
        .addr_v     (addr_v),
`ifdef PIC_PAUSE_EN
        .pause      (pause_drv),
`endif
        .rom_address(rom_address),
        .pic_valid  (pic_valid),
        .pos_x      (pos_x),
        .pos_y      (pos_y)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_x = 296; mdl_y = 216; mdl_right = 1'b1; mdl_down = 1'b1;
        mdl_fcnt = 0; mdl_cnt = 0;
    endtask

    task automatic model_move();
        if (mdl_right) begin
            if (mdl_x + c_STEP >= c_XMAX) begin mdl_x = c_XMAX; mdl_right = 1'b0; end
            else mdl_x = mdl_x + c_STEP;
        end else begin
            if (mdl_x <= c_STEP) begin mdl_x = 0; mdl_right = 1'b1; end
            else mdl_x = mdl_x - c_STEP;
        end
        if (mdl_down) begin
            if (mdl_y + c_STEP >= c_YMAX) begin mdl_y = c_YMAX; mdl_down = 1'b0; end
            else mdl_y = mdl_y + c_STEP;
        end else begin
            if (mdl_y <= c_STEP) begin mdl_y = 0; mdl_down = 1'b1; end
            else mdl_y = mdl_y - c_STEP;
        end
    endtask

    // One pixel-clock cycle: check what matured, then push and drive the next pixel.
    task automatic tick(input logic pv, input int h, input int v);
        exp_t rec;
        exp_t last;
        logic hit;
        @(negedge vga_clk);
        if (pic_valid) pv_seen++;
        if (sb_q.size() == 2) begin
            rec = sb_q.pop_front();
            check_eq("pic_valid", 32'(pic_valid), 32'(rec.hit));
        end
        if (sb_q.size() > 0) begin
            last = sb_q[sb_q.size()-1];
            if (last.hit) check_eq("rom_address", 32'(rom_address), 32'(last.addr));
        end
        check_eq("pos_x", 32'(pos_x), 32'(mdl_x));
        check_eq("pos_y", 32'(pos_y), 32'(mdl_y));
        hit = pv && (h >= mdl_x) && (h <= mdl_x + 47) && (v >= mdl_y) && (v <= mdl_y + 47);
        rec.hit  = hit;
        rec.addr = 14'(mdl_cnt);
        sb_q.push_back(rec);
        if (pv && h == 639 && v == 479) begin
            mdl_cnt = 0;
            if (!pause_drv) begin
                if (mdl_fcnt == 1) begin mdl_fcnt = 0; model_move(); end
                else mdl_fcnt = mdl_fcnt + 1;
            end
        end else if (hit) begin
            mdl_cnt = (mdl_cnt == 2303) ? 0 : mdl_cnt + 1;
        end
        pix_valid = pv;
        addr_h    = 12'(h);
        addr_v    = 12'(v);
    endtask

    task automatic frame_end_only();
        tick(1'b1, 639, 479);
        tick(1'b0, 0, 0);
        tick(1'b0, 0, 0);
    endtask

    task automatic do_move();
        frame_end_only();
        frame_end_only();
    endtask

    // Window rows plus one outside pixel on each side, then the frame-end pixel.
    task automatic window_frame();
        int wx, wy;
        wx = mdl_x; wy = mdl_y;
        pv_seen = 0;
        for (int v = wy; v < wy + 48; v++)
            for (int h = wx - 1; h <= wx + 48; h++)
                if (h >= 0) tick(1'b1, h, v);
        check_eq("last_addr", 32'(rom_address), 32'd2303);
        tick(1'b0, 0, 0);
        frame_end_only();
        check_eq("valid_count", 32'(pv_seen), 32'd2304);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge vga_clk);
        check_eq("rst_rom_address", 32'(rom_address), 32'd0);
        check_eq("rst_pic_valid", 32'(pic_valid), 32'd0);
        check_eq("rst_pos_x", 32'(pos_x), 32'd296);
        check_eq("rst_pos_y", 32'(pos_y), 32'd216);
        rst_n = 1'b1;

        window_frame();
        check_eq("f1_pos_x", 32'(pos_x), 32'd296);
        check_eq("f1_pos_y", 32'(pos_y), 32'd216);
        window_frame();
        check_eq("f2_pos_x", 32'(pos_x), 32'd303);
        check_eq("f2_pos_y", 32'(pos_y), 32'd223);

        // Partial frame up to pixel (320,240), then asynchronous reset.
        for (int v = 223; v <= 240; v++)
            for (int h = 302; h <= (v == 240 ? 320 : 351); h++)
                tick(1'b1, h, v);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rom_address", 32'(rom_address), 32'd0);
        check_eq("mid_rst_pic_valid", 32'(pic_valid), 32'd0);
        check_eq("mid_rst_pos_x", 32'(pos_x), 32'd296);
        check_eq("mid_rst_pos_y", 32'(pos_y), 32'd216);
        pix_valid = 1'b0;
        model_reset();
        sb_q.delete();
        @(negedge vga_clk);
        rst_n = 1'b1;
        window_frame();

        frame_end_only();
        check_eq("m1_pos_x", 32'(pos_x), 32'd303);
        for (int m = 2; m <= 129; m++) begin
            do_move();
            case (m)
                30:  check_eq("y_pre_clamp", 32'(pos_y), 32'd426);
                31:  check_eq("y_clamp", 32'(pos_y), 32'd432);
                32:  check_eq("y_after_clamp", 32'(pos_y), 32'd425);
                42:  check_eq("x_pre_clamp", 32'(pos_x), 32'd590);
                43:  check_eq("x_clamp", 32'(pos_x), 32'd592);
                44:  check_eq("x_after_clamp", 32'(pos_x), 32'd585);
                127: check_eq("x_near_left", 32'(pos_x), 32'd4);
                128: check_eq("x_left_clamp", 32'(pos_x), 32'd0);
                129: check_eq("x_left_bounce", 32'(pos_x), 32'd7);
                default: ;
            endcase
        end
        window_frame();

`ifdef PIC_PAUSE_EN
        pause_drv = 1'b1;
        for (int k = 0; k < 3; k++) window_frame();
        check_eq("pause_pos_x", 32'(pos_x), 32'(mdl_x));
        pause_drv = 1'b0;
        do_move();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
